// File: rtl/shift_pkg.sv
// Shared constants for the iterative shifter: data width, op encodings, FSM states
// and the per-cycle step size helper.
package shift_pkg;

    localparam int DATA_W = 32;
    localparam int AMT_W  = 5;

    typedef logic [1:0] op_t;

    localparam op_t OP_SLL = 2'b00;
    localparam op_t OP_SRL = 2'b01;
    localparam op_t OP_SRA = 2'b10;
    localparam op_t OP_ROR = 2'b11;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Each SHIFT cycle moves two positions, or one when only one is left.
    function automatic logic [1:0] step_of(input logic [AMT_W-1:0] cnt);
        return (cnt >= AMT_W'(2)) ? 2'd2 : 2'd1;
    endfunction

endpackage

// File: rtl/shift_iter_if.sv
// Request/result bundle of the iterative shifter; master issues shifts, slave performs them.
interface shift_iter_if;
    import shift_pkg::*;

    logic              start;
    op_t               op;
    logic [AMT_W-1:0]  amt;
    logic [DATA_W-1:0] din;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] dout;

    modport master (output start, output op, output amt, output din,
                    input busy, input done, input dout);
    modport slave  (input start, input op, input amt, input din,
                    output busy, output done, output dout);

endinterface

// File: rtl/shift_iter_step.sv
// Combinational one-or-two position shift used once per SHIFT cycle.
// Rotate right for op=11 exists only when SHIFT_ROTATE_EN is defined; otherwise op=11 is SRL.
module shift_step
    import shift_pkg::*;
(
    input  logic [DATA_W-1:0] data,
    input  op_t               op,
    input  logic [1:0]        step,
    output logic [DATA_W-1:0] shifted
);

    logic [DATA_W-1:0] sll_c [1:2];
    logic [DATA_W-1:0] srl_c [1:2];
    logic [DATA_W-1:0] sra_c [1:2];
`ifdef SHIFT_ROTATE_EN
    logic [DATA_W-1:0] ror_c [1:2];
`endif

    genvar gi;
    generate
        for (gi = 1; gi <= 2; gi++) begin : g_step
            assign sll_c[gi] = {data[DATA_W-1-gi:0], {gi{1'b0}}};
            assign srl_c[gi] = {{gi{1'b0}}, data[DATA_W-1:gi]};
            // Bit 31 never changes under SRA, so it is still the captured sign.
            assign sra_c[gi] = {{gi{data[DATA_W-1]}}, data[DATA_W-1:gi]};
`ifdef SHIFT_ROTATE_EN
            assign ror_c[gi] = {data[gi-1:0], data[DATA_W-1:gi]};
`endif
        end
    endgenerate

    logic two;
    assign two = (step == 2'd2);

    always_comb begin
        shifted = data;
        case (op)
            OP_SLL:  shifted = two ? sll_c[2] : sll_c[1];
            OP_SRA:  shifted = two ? sra_c[2] : sra_c[1];
`ifdef SHIFT_ROTATE_EN
            OP_ROR:  shifted = two ? ror_c[2] : ror_c[1];
            default: shifted = two ? srl_c[2] : srl_c[1];
`else
            default: shifted = two ? srl_c[2] : srl_c[1];
`endif
        endcase
    end

endmodule

// File: rtl/shift_iter.sv
// Iterative 32-bit shifter: captures an operand, shifts up to two places per cycle,
// pulses done for one cycle. Optional rotate via SHIFT_ROTATE_EN (see shift_step).
module shift_iter
    import shift_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    shift_iter_if.slave  bus
);

    logic [1:0]        state_reg, state_next;
    logic [DATA_W-1:0] data_reg,  data_next;
    op_t               op_reg,    op_next;
    logic [AMT_W-1:0]  count_reg, count_next;

    logic [1:0]        step;
    logic [DATA_W-1:0] step_data;

    assign step = step_of(count_reg);

    shift_step u_step (
        .data    (data_reg),
        .op      (op_reg),
        .step    (step),
        .shifted (step_data)
    );

    always_comb begin
        state_next = state_reg;
        data_next  = data_reg;
        op_next    = op_reg;
        count_next = count_reg;
        case (state_reg)
            ST_SHIFT: begin
                data_next  = step_data;
                count_next = count_reg - {{(AMT_W-2){1'b0}}, step};
                if (count_next == '0)
                    state_next = ST_DONE;
            end
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    data_next  = bus.din;
                    op_next    = bus.op;
                    count_next = bus.amt;
                    state_next = (bus.amt == '0) ? ST_DONE : ST_SHIFT;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            data_reg  <= '0;
            op_reg    <= OP_SLL;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            data_reg  <= data_next;
            op_reg    <= op_next;
            count_reg <= count_next;
        end
    end

    assign bus.busy = (state_reg == ST_SHIFT);
    assign bus.done = (state_reg == ST_DONE);
    assign bus.dout = data_reg;

endmodule

// File: doc/shift_iter.md
SHIFT_ITER -- requirements
Module: shift_iter

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clk input 1 (rising-edge clock); rst input 1 (synchronous reset, active high).
REQ-002 SHALL have ports: start input 1 (request; sampled when not busy); op input 2 (00 SLL, 01 SRL, 10 SRA, 11 ROR/SRL); amt input 5 (shift amount 0..31); din input 32 (operand).
REQ-003 SHALL have ports: busy output 1 (high while shifting); done output 1 (one-cycle completion pulse); dout output 32 (result, held until next accepted start).

Function
REQ-004 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-005 SHALL accept start only in IDLE or DONE; on acceptance: capture din into the data register, op into the op register, amt into the count register.
REQ-006 SHALL transition on accepted start to DONE if amt=0, else to SHIFT.
REQ-007 SHALL in each SHIFT cycle apply a step of min(2,count) positions per captured op, subtract the step from count, and move to DONE when the new count is 0.
REQ-008 SHALL fill SLL with 0 from the LSB, SRL with 0 from the MSB, SRA with copies of the captured bit 31, and ROR with bits wrapped from the LSB side.
REQ-009 SHALL assert done for exactly one cycle while in DONE; DONE returns to IDLE unless start is accepted in that same cycle.
REQ-010 SHALL assert busy only in SHIFT; start while busy is ignored and changes no state.
REQ-011 SHALL produce done ceil(amt/2)+1 cycles after the accepting edge (amt=0 -> 1 cycle; amt=31 -> 17 cycles).
REQ-012 SHALL drive dout from the data register at all times; dout equals the final result while done=1 and holds it in IDLE.
REQ-013 SHALL ignore din/op/amt changes after acceptance; the result depends only on captured values.
REQ-014 SHALL support back-to-back operation: start in DONE loads the new operand on that edge, and done deasserts for at least one cycle unless the new amt=0.

Reset
REQ-015 SHALL on rst=1 at a rising edge go to IDLE, with busy=0, done=0, dout=0, count=0; rst overrides start.
REQ-016 SHALL abort any in-flight operation when rst is asserted mid-SHIFT, with no done pulse produced.

Configuration
REQ-017 SHALL use macro SHIFT_ROTATE_EN: when defined, op=11 performs rotate right.
REQ-018 SHALL, when SHIFT_ROTATE_EN is undefined, execute op=11 exactly as SRL (01) and contain no rotate logic.

Structure
REQ-019 SHALL place op encodings (OP_SLL, OP_SRL, OP_SRA, OP_ROR), FSM state encodings, and the data width constant (32) in the shared package shift_pkg.
REQ-020 SHALL implement the per-cycle data transform in one combinational sub-module shift_step (inputs data, op, step of 1 or 2; output shifted data), instantiated once.

Verification
REQ-021 SHALL cover SRA: din=0x80000010, amt=5, op=10 -> done 4 cycles after start, dout=0xFC000000.
REQ-022 SHALL cover SLL and SRL boundaries: din=0x00000001, amt=31, op=00 -> dout=0x80000000 after 17 cycles; din=0xFFFFFFFF, amt=0, op=01 -> dout=0xFFFFFFFF, done 1 cycle after start.
REQ-023 SHALL cover ROR: din=0x00000003, amt=1, op=11 -> dout=0x80000001 with SHIFT_ROTATE_EN defined, 0x00000001 without it.
REQ-024 SHALL cover busy handling: start pulsed mid-SHIFT with different din -> ignored, first result unchanged; start in DONE cycle with amt=2 -> second result 2 cycles later.
REQ-025 SHALL cover reset: rst asserted in 2nd SHIFT cycle of amt=8 -> next cycle busy=0, dout=0, no done pulse; a new start afterward completes normally.
